// File: rtl/lfsr_sched.sv
// lfsr_sched: owns seeding and warm-up of a shared 8-bit LFSR and hands out
// stride-spaced random bytes to NUM_REQ round-robin requesters.
module lfsr_sched #(
  parameter int NUM_REQ = 4,
  parameter int STRIDE = 8,
  parameter int WARMUP = 16,
  parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_seed_load,
  input  logic [7:0]         cfg_seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         rnd_data,
  output logic               rnd_valid,
  output logic               rng_ready,
  output logic               lfsr_write_enable,
  output logic [7:0]         lfsr_seed,
  input  logic [7:0]         lfsr_bits
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {INIT, SEED, WARM, RUN} state_t;
  state_t state, state_nx;
  logic [7:0] wcnt, scnt;
  logic [PW-1:0] rr_ptr, winner;
  logic reseed, grant_edge;
  always_comb begin
    reseed = cfg_seed_load && state != INIT;
    grant_edge = state == RUN && scnt == 8'(STRIDE) && |req && !cfg_seed_load;
    state_nx = reseed ? SEED :
               state == INIT ? SEED :
               state == SEED ? WARM :
               (state == WARM && wcnt == 8'(WARMUP)) ? RUN : state;
    // Lowest set bit above rr_ptr wins; otherwise wrap to the lowest set bit overall.
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) winner = PW'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i] && i > int'(rr_ptr)) winner = PW'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      gnt <= '0;
      rnd_valid <= 1'b0;
      rnd_data <= '0;
      rng_ready <= 1'b0;
      lfsr_write_enable <= 1'b0;
      lfsr_seed <= DEFAULT_SEED;
      wcnt <= '0;
      scnt <= '0;
      rr_ptr <= PW'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      lfsr_write_enable <= state_nx == SEED;
      rng_ready <= state_nx == RUN;
      gnt <= grant_edge ? ONE << winner : '0;
      rnd_valid <= grant_edge;
      if (grant_edge) begin
        rnd_data <= lfsr_bits;
        rr_ptr <= winner;
      end
      if (reseed) lfsr_seed <= cfg_seed == 8'd0 ? DEFAULT_SEED : cfg_seed;
      else if (state == INIT) lfsr_seed <= DEFAULT_SEED;
      wcnt <= state_nx != WARM ? 8'd0 : state == WARM ? wcnt + 8'd1 : 8'd1;
      scnt <= state_nx != RUN ? 8'd0 :
              state != RUN ? 8'(STRIDE) :
              grant_edge ? 8'd1 :
              scnt == 8'(STRIDE) ? scnt : scnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: directed table, corner sequences and a randomized run against a timestamp-based reference model.
module tb_lfsr_sched;
  localparam int NUM_REQ = 4;
  localparam int STRIDE = 8;
  localparam int WARMUP = 16;
  localparam logic [7:0] DSEED = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_seed_load = 1'b0;
  logic [7:0] cfg_seed = 8'd0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] gnt;
  logic [7:0] rnd_data, lfsr_seed, lfsr_bits;
  logic rnd_valid, rng_ready, lfsr_write_enable;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int seed_cyc = 0;
  logic [7:0] cur_seed = DSEED;

  lfsr_sched #(.NUM_REQ(NUM_REQ), .STRIDE(STRIDE), .WARMUP(WARMUP), .DEFAULT_SEED(DSEED)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_seed_load(cfg_seed_load), .cfg_seed(cfg_seed),
    .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rng_ready(rng_ready),
    .lfsr_write_enable(lfsr_write_enable), .lfsr_seed(lfsr_seed), .lfsr_bits(lfsr_bits)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared LFSR: shift left, feedback is bits 7^6 delayed by one cycle.
  logic lf_fb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_bits <= '0;
      lf_fb <= 1'b0;
    end else if (lfsr_write_enable) begin
      lfsr_bits <= lfsr_seed;
      lf_fb <= 1'b0;
    end else begin
      lfsr_bits <= {lfsr_bits[6:0], lf_fb};
      lf_fb <= lfsr_bits[7] ^ lfsr_bits[6];
    end
  end

  function automatic logic [7:0] lfsr_after(input logic [7:0] s, input int n);
    logic [7:0] b;
    logic f, nf;
    b = s;
    f = 1'b0;
    for (int k = 0; k < n; k++) begin
      nf = b[7] ^ b[6];
      b = {b[6:0], f};
      f = nf;
    end
    return b;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] rq, input int rr);
    for (int d = 1; d <= NUM_REQ; d++)
      if (rq[(rr + d) % NUM_REQ]) return (rr + d) % NUM_REQ;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Leaves the bench at the negedge of the SEED cycle; init_cfg pulses a reseed in INIT, which must be ignored.
  task automatic reset_and_release(input bit init_cfg);
    rst_n = 1'b0;
    req = '0;
    cfg_seed_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_valid", rnd_valid, 0);
    check("rst_data", rnd_data, 0);
    check("rst_ready", rng_ready, 0);
    check("rst_we", lfsr_write_enable, 0);
    check("rst_seed", lfsr_seed, DSEED);
    rst_n = 1'b1;
    cfg_seed_load = init_cfg;
    cfg_seed = 8'h77;
    @(negedge clk);
    cfg_seed_load = 1'b0;
  endtask

  // Called at the negedge of a SEED cycle; returns at the negedge of the first RUN cycle.
  task automatic seed_warm(input logic [7:0] s, input string tag);
    int bad = 0;
    check({tag, "_we"}, lfsr_write_enable, 1);
    check({tag, "_seed"}, lfsr_seed, s);
    check({tag, "_ready_low"}, rng_ready, 0);
    seed_cyc = cyc;
    cur_seed = s;
    repeat (WARMUP) begin
      @(negedge clk);
      if (rng_ready || lfsr_write_enable || rnd_valid || gnt != 0) bad++;
    end
    check({tag, "_warm_quiet"}, bad, 0);
    @(negedge clk);
    check({tag, "_ready"}, rng_ready, 1);
    check({tag, "_no_early_gnt"}, gnt, 0);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
  } vec_t;
  vec_t tbl[12];

  int m_seed_cyc, m_last, m_rr, w, run_start, prev_g, got_g;
  logic [7:0] m_seed, m_data;
  logic [NUM_REQ-1:0] m_gnt;
  bit found;

  initial begin
    tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
            '{4'b1111, 4'b0001}, '{4'b1010, 4'b0010}, '{4'b0101, 4'b0100}, '{4'b0011, 4'b0001},
            '{4'b1000, 4'b1000}, '{4'b1000, 4'b1000}, '{4'b0110, 4'b0010}, '{4'b1101, 4'b0100}};

    reset_and_release(1'b0);
    seed_warm(DSEED, "s1");

    run_start = cyc;
    prev_g = -1;
    foreach (tbl[i]) begin
      req = tbl[i].req;
      found = 1'b0;
      for (int t = 0; t < 3 * STRIDE && !found; t++) begin
        @(negedge clk);
        found = gnt != 0;
      end
      check("tbl_grant_seen", found, 1);
      got_g = cyc;
      check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      check($sformatf("tbl%0d_valid", i), rnd_valid, 1);
      check($sformatf("tbl%0d_data", i), rnd_data, lfsr_after(cur_seed, got_g - seed_cyc - 2));
      check($sformatf("tbl%0d_gap", i), got_g - (i == 0 ? run_start : prev_g), i == 0 ? 1 : STRIDE);
      prev_g = got_g;
    end
    req = '0;

    cfg_seed_load = 1'b1;
    cfg_seed = 8'h00;
    @(negedge clk);
    cfg_seed_load = 1'b0;
    seed_warm(DSEED, "s3");

    req = 4'b0100;
    cfg_seed_load = 1'b1;
    cfg_seed = 8'h3C;
    @(negedge clk);
    cfg_seed_load = 1'b0;
    check("s4_nogrant", gnt, 0);
    seed_warm(8'h3C, "s4");
    @(negedge clk);
    check("s4_gnt", gnt, 4'b0100);
    check("s4_data", rnd_data, lfsr_after(8'h3C, cyc - seed_cyc - 2));
    req = '0;

    cfg_seed_load = 1'b1;
    cfg_seed = 8'h5A;
    @(negedge clk);
    cfg_seed_load = 1'b0;
    check("s5_we", lfsr_write_enable, 1);
    check("s5_seed", lfsr_seed, 8'h5A);
    repeat (10) @(negedge clk);
    check("s5_ready_low", rng_ready, 0);
    cfg_seed_load = 1'b1;
    cfg_seed = 8'hC3;
    @(negedge clk);
    cfg_seed_load = 1'b0;
    seed_warm(8'hC3, "s5r");

    req = 4'b1111;
    found = 1'b0;
    for (int t = 0; t < 5 * STRIDE && !found; t++) begin
      @(negedge clk);
      found = gnt == 4'b0010;
    end
    check("s6_gnt1_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("s6_async_gnt", gnt, 0);
    check("s6_async_valid", rnd_valid, 0);
    check("s6_async_ready", rng_ready, 0);
    reset_and_release(1'b1);
    seed_warm(DSEED, "s6");
    req = 4'b1111;
    @(negedge clk);
    check("s6_first_gnt", gnt, 4'b0001);
    req = '0;

    reset_and_release(1'b0);
    m_seed_cyc = cyc;
    m_seed = DSEED;
    m_last = -1000;
    m_rr = NUM_REQ - 1;
    m_gnt = '0;
    m_data = '0;
    for (int k = 0; k < 4000; k++) begin
      check("rnd_gnt", gnt, m_gnt);
      check("rnd_valid", rnd_valid, m_gnt != 0);
      check("rnd_data", rnd_data, m_data);
      check("rnd_ready", rng_ready, cyc >= m_seed_cyc + WARMUP + 1);
      check("rnd_we", lfsr_write_enable, cyc == m_seed_cyc);
      check("rnd_seed", lfsr_seed, m_seed);
      req = $urandom_range(0, 7) == 0 ? NUM_REQ'($urandom) : req & ~m_gnt;
      cfg_seed_load = $urandom_range(0, 59) == 0;
      cfg_seed = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      m_gnt = '0;
      if (cfg_seed_load) begin
        m_seed_cyc = cyc + 1;
        m_seed = cfg_seed == 0 ? DSEED : cfg_seed;
      end else if (cyc >= m_seed_cyc + WARMUP + 1 && req != 0 &&
                   (m_last <= m_seed_cyc + WARMUP + 1 || cyc - m_last >= STRIDE - 1)) begin
        w = pick(req, m_rr);
        m_rr = w;
        m_gnt = NUM_REQ'(1) << w;
        m_data = lfsr_after(m_seed, cyc - m_seed_cyc - 1);
        m_last = cyc + 1;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/lfsr_sched.md
Name: lfsr_sched

Overview:
- Scheduler that shares one 8-bit LFSR (`clk`/`rst_n`, `write_enable`, `seed[7:0]`, `lfsr_bits[7:0]`) between NUM_REQ requesters.
- Owns seeding: the default seed after reset, runtime reseeds, and all-zero seed substitution. Enforces a warm-up period after every seed load.
- Spaces grants at least STRIDE LFSR shifts apart, so each requester receives a fresh byte and never a shifted copy of a neighbour's byte.
- Sits between the LFSR instance and the consumer blocks (e.g. game logic, noise generators) in the top level.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- STRIDE, 8: minimum LFSR shifts between consecutive samples, range 1..255.
- WARMUP, 16: cycles the LFSR free-runs after a seed load before sampling is allowed. Must be >= STRIDE and >= 2, range 2..255.
- DEFAULT_SEED, 8'hA5: seed loaded after reset and substituted for an all-zero seed. Must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_seed_load  in  1  one-cycle pulse: reseed the LFSR with cfg_seed.
- cfg_seed  in  8  seed value, sampled when cfg_seed_load=1.
- req  in  NUM_REQ  per-requester request. Held high until the matching gnt bit.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rnd_data  out  8  random byte; valid with rnd_valid.
- rnd_valid  out  1  high in the same cycle as any gnt bit.
- rng_ready  out  1  high while in the RUN state.
- lfsr_write_enable  out  1  to LFSR write_enable.
- lfsr_seed  out  8  to LFSR seed.
- lfsr_bits  in  8  from LFSR lfsr_bits.

Behaviour:
Reset (rst_n=0), applied asynchronously:
- state=INIT; gnt=0; rnd_valid=0; rnd_data=0; rng_ready=0.
- lfsr_write_enable=0; lfsr_seed=DEFAULT_SEED.
- wcnt=0; scnt=0; rr_ptr=NUM_REQ-1, so req[0] has highest priority first.
- The LFSR shares rst_n; its own reset value is irrelevant because INIT reseeds it.

All outputs are registered. States are INIT, SEED, WARMUP, RUN.
- INIT: lasts one cycle after reset release; go to SEED with lfsr_seed=DEFAULT_SEED.
- SEED: lasts one cycle; lfsr_write_enable=1. Next state WARMUP with wcnt=1.
- WARMUP:
  - wcnt increments each cycle.
  - When wcnt==WARMUP, go to RUN with scnt=STRIDE.
  - Total time from the SEED cycle to the first rng_ready=1 cycle is WARMUP+1 cycles.
  - The warm-up also flushes the LFSR's one-cycle-delayed feedback register.
- RUN:
  - scnt increments each cycle, saturating at STRIDE.
  - A grant edge occurs when scnt==STRIDE and |req is true. At that edge:
    - gnt<=onehot(winner); rnd_data<=lfsr_bits; rnd_valid<=1.
    - rr_ptr<=winner; scnt<=1.
  - Winner selection: the first set req bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Next cycle: gnt=0 and rnd_valid=0 unless a new grant edge occurs, which requires STRIDE==1.
  - Under continuous load, grants are exactly STRIDE cycles apart.

Reseed:
- When cfg_seed_load=1 in any state other than INIT, at that edge:
  - lfsr_seed<=(cfg_seed==0 ? DEFAULT_SEED : cfg_seed); state<=SEED.
  - rng_ready<=0 at that edge.
- cfg_seed_load takes priority over a grant edge in the same cycle: no grant; requests stay pending.
- A reseed during WARMUP restarts the warm-up from SEED.
- cfg_seed_load in INIT is ignored.

Grant and request rules:
- req bits that drop before their grant are simply not served; there is no error.
- At most one gnt bit is high in any cycle.
- rnd_valid==|gnt in every cycle.

lfsr_write_enable is high only in the SEED state.

Reset mid-operation: all outputs return to their reset values immediately. No partial grant is visible.

Test Plan:
Common configuration: NUM_REQ=4, STRIDE=8, WARMUP=16, DEFAULT_SEED=A5. Reference model: shift register with delayed XOR of bits 7 and 6.
1. Release reset, req=0.
   - Cycle 2 after release: lfsr_write_enable=1, lfsr_seed=A5.
   - rng_ready rises 17 cycles after the SEED cycle; gnt stays 0.
2. After rng_ready, hold req=4'b1111.
   - Grants go 0,1,2,3,0, exactly 8 cycles apart.
   - Each rnd_data matches the model's lfsr_bits at that grant edge; gnt is one-hot with rnd_valid.
3. In RUN, pulse cfg_seed_load with cfg_seed=00.
   - lfsr_seed=A5 and lfsr_write_enable=1 for one cycle.
   - rng_ready is low for 17 cycles; no grants during that time.
4. With req[2] held and scnt==STRIDE, pulse cfg_seed_load (cfg_seed=3C) in the grant-eligible cycle.
   - No gnt that cycle; lfsr_seed=3C.
   - req[2] is granted on the first RUN cycle after warm-up.
5. During WARMUP at wcnt=10, pulse cfg_seed_load.
   - Warm-up restarts; rng_ready rises 17 cycles after the new SEED cycle.
6. Assert rst_n=0 asynchronously in the cycle gnt[1]=1.
   - gnt, rnd_valid and rng_ready clear immediately, without a clock edge.
   - After release, the scenario 1 sequence repeats.
